sd_drive_arbiter: RTL and testbench

Round-robin arbiter that shares the single HPS virtual-disk sector channel (lba/rd/wr/ack/buffer) among NBDRIV floppy drive requesters. It replaces the current OR-ed ack and shared-lba wiring with one owned transaction at a time. It latches the winning drive's LBA and steers buffer data to and from that drive only. It also recovers from a host that never acknowledges a request.

---
 rtl/sd_arb_pkg.sv | 42 ++++
 rtl/sd_drive_arbiter_rr_picker.sv | 45 ++++
 rtl/sd_drive_arbiter.sv | 142 ++++++++++++++
 tb/tb_sd_drive_arbiter.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sd_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : sd_arb_pkg
//  Purpose  : Shared types and helpers for the SD drive arbiter: arbiter
//             state encoding, bus widths and a reference round-robin pick.
//  Revision : 1.0 - initial release
// ============================================================================
package sd_arb_pkg;

  localparam int LBA_W    = 32;
  localparam int BYTE_W   = 8;
  localparam int MAX_DRIV = 8;
  localparam int IDX_W    = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    XFER = 2'd2,
    DONE = 2'd3
  } arb_state_t;

  // Next index at or after (rr+1) mod n that is pending, wrapping; returns rr
  // when nothing is pending. n must be a constant at the call site.
  function automatic logic [IDX_W-1:0] rr_pick(
    input logic [MAX_DRIV-1:0] pending,
    input logic [IDX_W-1:0]    rr,
    input int                  n
  );
    logic [IDX_W-1:0] pick;
    int               idx;
    pick = rr;
    for (int k = MAX_DRIV; k >= 1; k--) begin
      if (k <= n) begin
        idx = (int'(rr) + k) % n;
        if (pending[idx[IDX_W-1:0]]) pick = idx[IDX_W-1:0];
      end
    end
    return pick;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sd_drive_arbiter_rr_picker.sv
`default_nettype none
// ============================================================================
//  Module   : rr_picker
//  Purpose  : Combinational round-robin first-one finder. Rotates the pending
//             vector so that (rr+1) sits at bit 0, finds the lowest set bit,
//             then maps the offset back to an absolute drive index.
//  Revision : 1.0 - initial release
// ============================================================================
module rr_picker #(
  parameter int NBDRIV = 4,
  parameter int GW     = 2
) (
  input  logic [NBDRIV-1:0] pending,
  input  logic [GW-1:0]     rr,
  output logic [GW-1:0]     pick,
  output logic              any
);

  // One extra bit so base+offset (< 2*NBDRIV) never overflows before the wrap.
  localparam int SW = GW + 1;

  logic [SW-1:0]       base;
  logic [SW-1:0]       off;
  logic [SW-1:0]       sum;
  logic [NBDRIV-1:0]   rot;
  logic [2*NBDRIV-1:0] dbl;

  // Rotate-and-search; the doubled vector makes the rotate a plain shift.
  always_comb begin
    base = SW'(rr) + SW'(1);
    if (base >= SW'(NBDRIV)) base = base - SW'(NBDRIV);
    dbl = {pending, pending};
    rot = NBDRIV'(dbl >> base);
    off = '0;
    for (int k = NBDRIV - 1; k >= 0; k--) begin
      if (rot[k]) off = SW'(k);
    end
    sum = base + off;
    if (sum >= SW'(NBDRIV)) sum = sum - SW'(NBDRIV);
    pick = GW'(sum);
    any  = |pending;
  end

endmodule
`default_nettype wire

// File: rtl/sd_drive_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : sd_drive_arbiter
//  Purpose  : Shares the single host virtual-disk sector channel among NBDRIV
//             floppy drives. One transaction is owned at a time: the winner's
//             LBA is latched, strobes/acks are one-hot to that drive, buffer
//             traffic is steered to it only, and a silent host is abandoned
//             after 2^TIMEOUT_W-1 request cycles.
//  Revision : 1.0 - initial release
// ============================================================================
module sd_drive_arbiter
  import sd_arb_pkg::*;
#(
  parameter int NBDRIV    = 4,
  parameter int GW        = 2,
  parameter int TIMEOUT_W = 24
) (
  input  logic                     clk_sys,
  input  logic                     reset_n,
  input  logic [NBDRIV-1:0]        req_rd,
  input  logic [NBDRIV-1:0]        req_wr,
  input  logic [NBDRIV*LBA_W-1:0]  req_lba,
  input  logic [NBDRIV*BYTE_W-1:0] req_buff_din,
  output logic [NBDRIV-1:0]        req_ack,
  output logic [NBDRIV-1:0]        req_done,
  output logic [NBDRIV-1:0]        req_buff_wr,
  output logic [LBA_W-1:0]         sd_lba,
  output logic [NBDRIV-1:0]        sd_rd,
  output logic [NBDRIV-1:0]        sd_wr,
  input  logic [NBDRIV-1:0]        sd_ack,
  input  logic                     sd_buff_wr,
  output logic [BYTE_W-1:0]        sd_buff_din,
  output logic [GW-1:0]            grant,
  output logic                     busy,
  output logic                     timeout_err
);

  // Last counter value before the increment would reach all-ones; the REQ
  // phase therefore lasts exactly 2^TIMEOUT_W-1 cycles without an ack.
  localparam logic [TIMEOUT_W-1:0] CNT_LAST = {{(TIMEOUT_W-1){1'b1}}, 1'b0};

  arb_state_t           state;
  logic [GW-1:0]        rr;
  logic                 is_rd;
  logic [TIMEOUT_W-1:0] cnt;
  logic [NBDRIV-1:0]    pending;
  logic [NBDRIV-1:0]    grant_onehot;
  logic [GW-1:0]        pick;
  logic                 any_pending;

  assign pending      = req_rd | req_wr;
  assign grant_onehot = {{(NBDRIV-1){1'b0}}, 1'b1} << grant;

  rr_picker #(
    .NBDRIV (NBDRIV),
    .GW     (GW)
  ) u_picker (
    .pending (pending),
    .rr      (rr),
    .pick    (pick),
    .any     (any_pending)
  );

  // Transaction sequencer: arbitrate, strobe, wait for ack, transfer, holdoff.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      grant       <= '0;
      rr          <= '0;
      is_rd       <= 1'b0;
      cnt         <= '0;
      sd_lba      <= '0;
      sd_rd       <= '0;
      sd_wr       <= '0;
      req_ack     <= '0;
      req_done    <= '0;
      timeout_err <= 1'b0;
    end else begin
      req_done    <= '0;
      timeout_err <= 1'b0;
      case (state)
        IDLE: begin
          if (any_pending) begin
            grant  <= pick;
            sd_lba <= req_lba[pick*LBA_W +: LBA_W];
            is_rd  <= req_rd[pick];
            cnt    <= '0;
            state  <= REQ;
          end
        end
        REQ: begin
          if (sd_ack[grant]) begin
            sd_rd   <= '0;
            sd_wr   <= '0;
            req_ack <= grant_onehot;
            cnt     <= '0;
            state   <= XFER;
          end else if (cnt == CNT_LAST) begin
            sd_rd       <= '0;
            sd_wr       <= '0;
            timeout_err <= 1'b1;
            req_done    <= grant_onehot;
            cnt         <= '0;
            state       <= DONE;
          end else begin
            cnt   <= cnt + TIMEOUT_W'(1);
            sd_rd <= is_rd ? grant_onehot : '0;
            sd_wr <= is_rd ? '0 : grant_onehot;
          end
        end
        XFER: begin
          if (!sd_ack[grant]) begin
            req_ack  <= '0;
            req_done <= grant_onehot;
            rr       <= grant;
            state    <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Buffer steering is zero-latency and only open while the transfer is owned.
  always_comb begin
    req_buff_wr = '0;
    sd_buff_din = '0;
    if (state == XFER) begin
      req_buff_wr = sd_buff_wr ? grant_onehot : '0;
      sd_buff_din = req_buff_din[grant*BYTE_W +: BYTE_W];
    end
  end

  assign busy = (state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_sd_drive_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sd_drive_arbiter
//  Purpose  : Scoreboard bench for sd_drive_arbiter. Stimulus pushes the
//             expected completion record; a monitor pops it on req_done.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sd_drive_arbiter;

  localparam int N  = 4;
  localparam int GW = 2;
  localparam int TW = 4;

  logic            clk_sys = 1'b0;
  logic            reset_n;
  logic [N-1:0]    req_rd, req_wr;
  logic [N*32-1:0] req_lba;
  logic [N*8-1:0]  req_buff_din;
  logic [N-1:0]    req_ack, req_done, req_buff_wr;
  logic [31:0]     sd_lba;
  logic [N-1:0]    sd_rd, sd_wr, sd_ack;
  logic            sd_buff_wr;
  logic [7:0]      sd_buff_din;
  logic [GW-1:0]   grant;
  logic            busy, timeout_err;

  logic [N-1:0]    host_ack, stray_ack;
  bit              host_en, host_abort;
  int              host_nbytes;

  assign sd_ack = host_ack | stray_ack;

  always #5 clk_sys = ~clk_sys;

  sd_drive_arbiter #(.NBDRIV(N), .GW(GW), .TIMEOUT_W(TW)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n),
    .req_rd(req_rd), .req_wr(req_wr), .req_lba(req_lba), .req_buff_din(req_buff_din),
    .req_ack(req_ack), .req_done(req_done), .req_buff_wr(req_buff_wr),
    .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr), .sd_ack(sd_ack),
    .sd_buff_wr(sd_buff_wr), .sd_buff_din(sd_buff_din),
    .grant(grant), .busy(busy), .timeout_err(timeout_err)
  );

  typedef struct {
    int          drive;
    bit          is_rd;
    logic [31:0] lba;
    int          nbuf;
    bit          tmo;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  task automatic push(input int d, input bit rd, input logic [31:0] lba, input int nb, input bit tmo);
    exp_t e;
    e.drive = d; e.is_rd = rd; e.lba = lba; e.nbuf = nb; e.tmo = tmo;
    exp_q.push_back(e);
  endtask

  // Waits (bounded) for a completion pulse, drops that drive's request level.
  task automatic wait_done_and_drop(output int cycles);
    int t;
    t = 0;
    do begin
      @(negedge clk_sys);
      t++;
    end while (req_done == '0 && t < 2000);
    cycles = t;
    if (req_done == '0) check("done_wait_expired", 32'(req_done), 32'hFFFF_FFFF);
    else begin
      req_rd = req_rd & ~req_done;
      req_wr = req_wr & ~req_done;
    end
  endtask

  task automatic wait_ack(input logic [N-1:0] mask);
    int t;
    t = 0;
    do begin
      @(negedge clk_sys);
      t++;
    end while ((req_ack & mask) == '0 && t < 2000);
    if ((req_ack & mask) == '0) check("ack_wait_expired", 32'(req_ack), 32'(mask));
  endtask

  // Host model: on a strobe, raise the ack, stream host_nbytes buffer writes
  // while in transfer, then drop the ack.
  initial begin
    logic [N-1:0] d;
    host_ack   = '0;
    sd_buff_wr = 1'b0;
    forever begin
      @(negedge clk_sys);
      if (host_en && reset_n && ((|sd_rd) || (|sd_wr))) begin
        d = sd_rd | sd_wr;
        @(posedge clk_sys); #1;
        host_ack = d;
        @(posedge clk_sys); #1;
        for (int b = 0; b < host_nbytes && !host_abort; b++) begin
          sd_buff_wr = 1'b1;
          @(posedge clk_sys); #1;
        end
        sd_buff_wr = 1'b0;
        host_ack   = '0;
      end
    end
  end

  // Monitor: accumulates strobes and steered buffer writes, scores on done.
  initial begin
    logic [N-1:0] seen_rd, seen_wr, oh;
    int           bcnt[N];
    int           others;
    bit           strobe_in_xfer;
    exp_t         e;
    seen_rd = '0; seen_wr = '0; strobe_in_xfer = 1'b0;
    foreach (bcnt[i]) bcnt[i] = 0;
    forever begin
      @(negedge clk_sys);
      if (!reset_n) begin
        seen_rd = '0; seen_wr = '0; strobe_in_xfer = 1'b0;
        foreach (bcnt[i]) bcnt[i] = 0;
      end else begin
        seen_rd |= sd_rd;
        seen_wr |= sd_wr;
        if ((|req_ack) && ((|sd_rd) || (|sd_wr))) strobe_in_xfer = 1'b1;
        for (int i = 0; i < N; i++) if (req_buff_wr[i]) bcnt[i]++;
        if (|req_done) begin
          if (exp_q.size() == 0) begin
            check("unexpected_done", 32'(req_done), 32'h0);
          end else begin
            e  = exp_q.pop_front();
            oh = N'(1) << e.drive;
            others = 0;
            for (int i = 0; i < N; i++) if (i != e.drive) others += bcnt[i];
            check("done_drive",     32'(req_done), 32'(oh));
            check("grant",          32'(grant),    32'(e.drive));
            check("rd_strobe",      32'(seen_rd),  e.is_rd ? 32'(oh) : 32'h0);
            check("wr_strobe",      32'(seen_wr),  e.is_rd ? 32'h0 : 32'(oh));
            check("lba",            sd_lba,        e.lba);
            check("buff_wr_count",  32'(bcnt[e.drive]), 32'(e.nbuf));
            check("stray_buff_wr",  32'(others),   32'h0);
            check("timeout_err",    32'(timeout_err), 32'(e.tmo));
            check("strobe_in_xfer", 32'(strobe_in_xfer), 32'h0);
          end
          seen_rd = '0; seen_wr = '0; strobe_in_xfer = 1'b0;
          foreach (bcnt[i]) bcnt[i] = 0;
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Directed stimulus.
  initial begin
    int cyc;
    reset_n = 1'b0; req_rd = '0; req_wr = '0; req_lba = '0; req_buff_din = '0;
    stray_ack = '0; host_en = 1'b0; host_abort = 1'b0; host_nbytes = 0;
    repeat (3) @(posedge clk_sys);
    @(negedge clk_sys);
    check("rst_busy",     32'(busy),     32'h0);
    check("rst_grant",    32'(grant),    32'h0);
    check("rst_strobes",  32'({sd_rd, sd_wr}), 32'h0);
    check("rst_ack_done", 32'({req_ack, req_done, req_buff_wr}), 32'h0);
    check("rst_lba",      sd_lba,        32'h0);
    check("rst_misc",     32'({timeout_err, sd_buff_din}), 32'h0);
    @(posedge clk_sys); #1 reset_n = 1'b1;

    // Round-robin from reset: all four pending, expect 1,2,3,0.
    for (int i = 0; i < N; i++) req_lba[32*i +: 32] = 32'h1000 + 32'(i);
    push(1, 1, 32'h1001, 3, 0);
    push(2, 1, 32'h1002, 3, 0);
    push(3, 1, 32'h1003, 3, 0);
    push(0, 1, 32'h1000, 3, 0);
    host_en = 1'b1; host_nbytes = 3;
    @(posedge clk_sys); #1 req_rd = 4'b1111;
    repeat (4) wait_done_and_drop(cyc);
    repeat (6) @(negedge clk_sys);
    check("rr_idle_after_4", 32'(busy), 32'h0);
    check("rr_queue_empty",  32'(exp_q.size()), 32'h0);

    // Single read on drive 2, 512 buffer writes, LBA change mid-flight ignored.
    req_lba[64 +: 32] = 32'h0000_0123;
    host_nbytes = 512;
    push(2, 1, 32'h123, 512, 0);
    @(posedge clk_sys); #1 req_rd = 4'b0100;
    @(posedge clk_sys); @(negedge clk_sys);
    check("strobe_lat_1cyc", 32'(sd_rd), 32'h0);
    check("grant_latched",   32'(grant), 32'h2);
    @(posedge clk_sys); @(negedge clk_sys);
    check("strobe_lat_2cyc", 32'(sd_rd), 32'b0100);
    check("sd_lba",          sd_lba,     32'h123);
    req_lba[64 +: 32] = 32'hDEAD_BEEF;
    wait_done_and_drop(cyc);

    // Write steering on drive 1.
    req_lba[32 +: 32] = 32'h0000_0200;
    req_buff_din = {8'h00, 8'h00, 8'hA5, 8'h00};
    host_nbytes = 4;
    push(1, 0, 32'h200, 4, 0);
    @(posedge clk_sys); #1 req_wr = 4'b0010;
    wait_ack(4'b0010);
    check("sd_buff_din", 32'(sd_buff_din), 32'hA5);
    wait_done_and_drop(cyc);

    // rd and wr together on drive 0: read wins.
    req_lba[0 +: 32] = 32'h0000_0300;
    host_nbytes = 2;
    push(0, 1, 32'h300, 2, 0);
    @(posedge clk_sys); #1 begin req_rd = 4'b0001; req_wr = 4'b0001; end
    wait_done_and_drop(cyc);

    // Timeout on drive 3 with a silent host.
    host_en = 1'b0;
    req_lba[96 +: 32] = 32'h0000_0400;
    push(3, 1, 32'h400, 0, 1);
    @(posedge clk_sys); #1 req_rd = 4'b1000;
    wait_done_and_drop(cyc);
    check("timeout_latency", 32'(cyc),   32'd17);
    check("timeout_sd_rd",   32'(sd_rd), 32'h0);
    repeat (2) @(negedge clk_sys);
    check("timeout_idle",    32'(busy),  32'h0);

    // Stray ack on drive 1 during drive 0 transfer, then reset mid-transfer.
    host_en = 1'b1; host_nbytes = 40;
    req_lba[0 +: 32] = 32'h0000_0500;
    @(posedge clk_sys); #1 req_rd = 4'b0001;
    wait_ack(4'b0001);
    @(posedge clk_sys); #1 stray_ack = 4'b0010;
    repeat (3) @(negedge clk_sys);
    check("stray_req_ack",  32'(req_ack),  32'b0001);
    check("stray_no_done",  32'(req_done), 32'h0);
    check("stray_busy",     32'(busy),     32'h1);
    @(posedge clk_sys); #1;
    reset_n = 1'b0; host_abort = 1'b1; stray_ack = '0;
    #1;
    check("async_rst_ack",    32'(req_ack),     32'h0);
    check("async_rst_sd_rd",  32'(sd_rd),       32'h0);
    check("async_rst_busy",   32'(busy),        32'h0);
    check("async_rst_grant",  32'(grant),       32'h0);
    check("async_rst_buffwr", 32'(req_buff_wr), 32'h0);
    req_rd = '0; host_en = 1'b0;
    repeat (3) @(posedge clk_sys);
    #1 begin reset_n = 1'b1; host_abort = 1'b0; end
    repeat (5) @(negedge clk_sys);
    check("post_rst_idle", 32'(busy), 32'h0);

    // After reset rr=0: drives 0 and 2 pending, expect 2 then 0 (wrap).
    host_en = 1'b1; host_nbytes = 1;
    req_lba[64 +: 32] = 32'h0000_0602;
    req_lba[0 +: 32]  = 32'h0000_0600;
    push(2, 1, 32'h602, 1, 0);
    push(0, 1, 32'h600, 1, 0);
    @(posedge clk_sys); #1 req_rd = 4'b0101;
    repeat (2) wait_done_and_drop(cyc);
    repeat (4) @(negedge clk_sys);
    check("final_queue_empty", 32'(exp_q.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
